traffic_input_conditioner: RTL and testbench
============================================

Name: traffic_input_conditioner

Overview:
- Consumer-side partner of the input synchronizer; takes the already-synchronized Sensor, Walk_Request and Reprogram levels and converts them into the event and handshake signals used by the traffic light FSM.
- Debounces the car sensor, latches pedestrian walk requests until the FSM acknowledges them, and emits a single-cycle reprogram strobe.
- Sits between the synchronizer and the main FSM / timer-parameter block, in the single `clock` domain.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical Sensor_Sync samples required before Sensor_Valid changes; legal range 1..255.
- CNT_W, 8: width of the debounce counter and of WR_Count.

Ports:
- clock  input  1  system clock; all logic is rising-edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Sensor_Sync  input  1  synchronized car-sensor level.
- WR_Sync  input  1  synchronized walk-request level.
- Prog_Sync  input  1  synchronized reprogram level.
- WR_Ack  input  1  FSM pulse: walk request has been serviced.
- Sensor_Valid  output  1  debounced sensor level.
- Walk_Pending  output  1  a walk request is latched and awaiting service.
- Prog_Pulse  output  1  one-cycle strobe on a Prog_Sync rising edge.
- WR_Count  output  CNT_W  walk requests accepted since reset; saturating.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - Sensor_Valid=0, Walk_Pending=0, Prog_Pulse=0, WR_Count=0.
  - Debounce counter=0; previous-sample registers for WR_Sync and Prog_Sync=0; walk FSM=IDLE.
  - Reset asserted mid-operation discards any pending request or debounce progress immediately.
- Sensor debounce:
  - Each cycle in which Sensor_Sync != Sensor_Valid, the counter increments. When the counter reaches DEBOUNCE_CYCLES-1 and the mismatch is still present, Sensor_Valid takes Sensor_Sync on that edge and the counter clears.
  - Any cycle with Sensor_Sync == Sensor_Valid clears the counter.
  - Result: a stable change shows on Sensor_Valid exactly DEBOUNCE_CYCLES clocks after the first differing sample. Glitches shorter than DEBOUNCE_CYCLES cycles never propagate.
  - With DEBOUNCE_CYCLES=1, Sensor_Valid follows Sensor_Sync with 1-cycle latency.
- Reprogram strobe:
  - Prog_Pulse is registered: it equals 1 for exactly the one cycle after the edge on which Prog_Sync=1 and the previous sample=0. This gives 1-cycle latency from the rising edge.
  - A held Prog_Sync produces no further pulses. A new pulse requires Prog_Sync to return low for at least 1 cycle.
- Walk request FSM, states IDLE, PENDING, HOLD:
  - IDLE: a rising edge on WR_Sync -> PENDING. Walk_Pending=1 from the next cycle; WR_Count increments, saturating at all-ones.
  - PENDING: Walk_Pending=1.
    - WR_Ack=1 -> HOLD if WR_Sync=1, else -> IDLE.
    - Further WR_Sync edges while PENDING are merged: no count increment, no state change.
  - HOLD: Walk_Pending=0. Waits for WR_Sync=0, then -> IDLE. This stops a button that is still held from re-latching.
  - WR_Ack in IDLE or HOLD is ignored.
  - A WR_Sync rising edge in the same cycle as WR_Ack while in PENDING: the ack wins (request serviced), the edge is not re-latched, and the state goes to HOLD.
  - Walk_Pending is a registered output that reflects state==PENDING.
- All outputs are registered; there is no combinational path from input to output.

Test Plan:
- Reset_n=0 with all inputs=1 -> all outputs 0. Release reset and hold Sensor_Sync=1 -> Sensor_Valid=1 exactly 4 clocks after the first sample (DEBOUNCE_CYCLES=4).
- Sensor_Sync 1-cycle and 3-cycle high glitches -> Sensor_Valid stays 0 and the counter clears after each glitch.
- Prog_Sync held high for 10 cycles, then low for 1, then high -> exactly two Prog_Pulse cycles, each 1 cycle long, each 1 cycle after its rising edge.
- WR_Sync pulses high for 2 cycles -> Walk_Pending=1 and WR_Count=1. Two more WR_Sync pulses while pending -> WR_Count stays 1. WR_Ack pulse -> Walk_Pending=0 next cycle, state IDLE.
- WR_Sync held high, WR_Ack pulse -> Walk_Pending falls and stays 0 while WR_Sync is high. WR_Sync low then high -> Walk_Pending=1 again and WR_Count=2.
- WR_Count saturation: 260 request/ack cycles -> WR_Count=255. Reset_n asserted while PENDING -> Walk_Pending=0 and WR_Count=0 without waiting for a clock edge.

Source files
------------

// File: rtl/traffic_input_conditioner.sv
// traffic_input_conditioner
// Turns the synchronized Sensor / Walk_Request / Reprogram levels into the
// debounced level, latched walk request and one-shot reprogram strobe that
// the traffic light FSM and timer-parameter block consume.
// Single clock domain; every output comes straight from a flop.

module traffic_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic             clock,
   input  logic             Reset_n,
   input  logic             Sensor_Sync,
   input  logic             WR_Sync,
   input  logic             Prog_Sync,
   input  logic             WR_Ack,
   output logic             Sensor_Valid,
   output logic             Walk_Pending,
   output logic             Prog_Pulse,
   output logic [CNT_W-1:0] WR_Count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      HOLD    = 2'd2
   } walk_state_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] db_cnt;
   logic             wr_prev;
   logic             prog_prev;
   logic             wr_rise;

   walk_state_t      state;
   walk_state_t      next_state;
   logic             count_inc;
   logic             pending_next;

   // Rising edge of the walk button: current sample high, previous sample low.
   assign wr_rise = WR_Sync & ~wr_prev;

   // Sensor debounce: count consecutive mismatching samples, adopt the new level
   // only once the mismatch has been seen DEBOUNCE_CYCLES times in a row.
   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge Reset_n) begin
      if (!Reset_n) begin
         db_cnt       <= '0;
         Sensor_Valid <= 1'b0;
      end else if (Sensor_Sync != Sensor_Valid) begin
         if (db_cnt == DB_LAST) begin
            Sensor_Valid <= Sensor_Sync;
            db_cnt       <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end else begin
         db_cnt <= '0;
      end
   end

   // Reprogram strobe: one registered pulse per low-to-high transition.
   always_ff @(posedge clock or negedge Reset_n) begin
      if (!Reset_n) begin
         prog_prev  <= 1'b0;
         Prog_Pulse <= 1'b0;
      end else begin
         prog_prev  <= Prog_Sync;
         Prog_Pulse <= Prog_Sync & ~prog_prev;
      end
   end

   // Walk FSM state register plus the flops that hold its registered outputs.
   always_ff @(posedge clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= IDLE;
         wr_prev      <= 1'b0;
         Walk_Pending <= 1'b0;
         WR_Count     <= '0;
      end else begin
         state        <= next_state;
         wr_prev      <= WR_Sync;
         Walk_Pending <= pending_next;
         if (count_inc && (WR_Count != {CNT_W{1'b1}})) begin
            WR_Count <= WR_Count + 1'b1;
         end
      end
   end

   // Walk FSM next-state: latch on an edge, release on ack, and keep a held
   // button from re-latching until it has been let go.
   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (wr_rise) next_state = PENDING;
         end
         PENDING: begin
            // Ack takes priority over a coincident new edge; edges while
            // pending are simply merged into the outstanding request.
            if (WR_Ack) next_state = WR_Sync ? HOLD : IDLE;
         end
         HOLD: begin
            if (!WR_Sync) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Walk FSM outputs: count only newly accepted requests, and present the
   // pending flag from a flop loaded with the upcoming state.
   always_comb begin
      count_inc    = (state == IDLE) && wr_rise;
      pending_next = (next_state == PENDING);
   end

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Directed bench for traffic_input_conditioner (DEBOUNCE_CYCLES=4, CNT_W=8).
// Vectors apply inputs just after a rising edge; outputs are checked 1 time
// unit after the following rising edge.

module tb_traffic_input_conditioner;

   localparam int CNT_W = 8;

   logic             clock;
   logic             Reset_n;
   logic             Sensor_Sync;
   logic             WR_Sync;
   logic             Prog_Sync;
   logic             WR_Ack;
   logic             Sensor_Valid;
   logic             Walk_Pending;
   logic             Prog_Pulse;
   logic [CNT_W-1:0] WR_Count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       s;
      logic       w;
      logic       p;
      logic       a;
      logic       exp_valid;
      logic       exp_pend;
      logic       exp_pulse;
      logic [7:0] exp_count;
   } vec_t;

   vec_t vecs[$];

   traffic_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W(CNT_W)
   ) dut (
      .clock(clock),
      .Reset_n(Reset_n),
      .Sensor_Sync(Sensor_Sync),
      .WR_Sync(WR_Sync),
      .Prog_Sync(Prog_Sync),
      .WR_Ack(WR_Ack),
      .Sensor_Valid(Sensor_Valid),
      .Walk_Pending(Walk_Pending),
      .Prog_Pulse(Prog_Pulse),
      .WR_Count(WR_Count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic add(input logic s, input logic w, input logic p, input logic a,
                      input logic ev, input logic ep, input logic eu, input logic [7:0] ec);
      vec_t v;
      v.s = s; v.w = w; v.p = p; v.a = a;
      v.exp_valid = ev; v.exp_pend = ep; v.exp_pulse = eu; v.exp_count = ec;
      vecs.push_back(v);
   endtask

   initial begin
      // ---- vector table: s w p a | valid pend pulse count ----
      // sensor returns low: 4 edges to follow
      add(0,0,0,0, 1,0,0,0);
      add(0,0,0,0, 1,0,0,0);
      add(0,0,0,0, 1,0,0,0);
      add(0,0,0,0, 0,0,0,0);
      // 1-cycle glitch
      add(1,0,0,0, 0,0,0,0);
      add(0,0,0,0, 0,0,0,0);
      // 3-cycle glitch
      add(1,0,0,0, 0,0,0,0);
      add(1,0,0,0, 0,0,0,0);
      add(1,0,0,0, 0,0,0,0);
      add(0,0,0,0, 0,0,0,0);
      // full 4-cycle change after glitches shows the counter was cleared
      add(1,0,0,0, 0,0,0,0);
      add(1,0,0,0, 0,0,0,0);
      add(1,0,0,0, 0,0,0,0);
      add(1,0,0,0, 1,0,0,0);
      // walk request 2 cycles high, then merged extra pulses
      add(1,1,0,0, 1,1,0,1);
      add(1,1,0,0, 1,1,0,1);
      add(1,0,0,0, 1,1,0,1);
      add(1,1,0,0, 1,1,0,1);
      add(1,0,0,0, 1,1,0,1);
      add(1,1,0,0, 1,1,0,1);
      add(1,0,0,0, 1,1,0,1);
      // ack with button released -> IDLE; ack in IDLE ignored
      add(1,0,0,1, 1,0,0,1);
      add(1,0,0,1, 1,0,0,1);
      // held button: ack -> HOLD, no re-latch while held
      add(1,1,0,0, 1,1,0,2);
      add(1,1,0,1, 1,0,0,2);
      add(1,1,0,0, 1,0,0,2);
      add(1,1,0,1, 1,0,0,2);
      add(1,0,0,0, 1,0,0,2);
      add(1,1,0,0, 1,1,0,3);
      // edge coincident with ack while pending: ack wins, goes to HOLD
      add(1,0,0,0, 1,1,0,3);
      add(1,1,0,1, 1,0,0,3);
      add(1,1,0,0, 1,0,0,3);
      add(1,0,0,0, 1,0,0,3);
      // reprogram held 10 cycles, low 1, high again
      add(1,0,1,0, 1,0,1,3);
      for (int i = 0; i < 9; i++) add(1,0,1,0, 1,0,0,3);
      add(1,0,0,0, 1,0,0,3);
      add(1,0,1,0, 1,0,1,3);
      add(1,0,1,0, 1,0,0,3);
      add(1,0,0,0, 1,0,0,3);

      // ---- reset with all inputs high ----
      Reset_n = 1'b0;
      Sensor_Sync = 1'b1; WR_Sync = 1'b1; Prog_Sync = 1'b1; WR_Ack = 1'b1;
      #3;
      check("rst_valid", Sensor_Valid, 0);
      check("rst_pend",  Walk_Pending, 0);
      check("rst_pulse", Prog_Pulse,   0);
      check("rst_count", WR_Count,     0);
      tick();
      tick();
      check("rst_hold_valid", Sensor_Valid, 0);
      check("rst_hold_pend",  Walk_Pending, 0);
      check("rst_hold_pulse", Prog_Pulse,   0);

      // ---- release reset with sensor held high: valid after exactly 4 edges ----
      WR_Sync = 1'b0; Prog_Sync = 1'b0; WR_Ack = 1'b0; Sensor_Sync = 1'b1;
      Reset_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check($sformatf("deb_rise_edge%0d", i), Sensor_Valid, (i == 4) ? 1 : 0);
      end

      // ---- table-driven vectors ----
      foreach (vecs[i]) begin
         Sensor_Sync = vecs[i].s;
         WR_Sync     = vecs[i].w;
         Prog_Sync   = vecs[i].p;
         WR_Ack      = vecs[i].a;
         tick();
         check($sformatf("v%0d_valid", i), Sensor_Valid, vecs[i].exp_valid);
         check($sformatf("v%0d_pend",  i), Walk_Pending, vecs[i].exp_pend);
         check($sformatf("v%0d_pulse", i), Prog_Pulse,   vecs[i].exp_pulse);
         check($sformatf("v%0d_count", i), WR_Count,     vecs[i].exp_count);
      end

      // ---- WR_Count saturation: 260 request/ack rounds starting from 3 ----
      for (int i = 0; i < 260; i++) begin
         WR_Sync = 1'b1; WR_Ack = 1'b0;
         tick();
         WR_Sync = 1'b0; WR_Ack = 1'b1;
         tick();
         WR_Ack = 1'b0;
         if (i == 250) check("sat_count_254", WR_Count, 254);
         if (i == 251) check("sat_count_255", WR_Count, 255);
      end
      check("sat_count_final", WR_Count, 255);
      check("sat_pend_final",  Walk_Pending, 0);

      // ---- asynchronous reset while pending ----
      WR_Sync = 1'b1;
      tick();
      check("pre_rst_pend", Walk_Pending, 1);
      #2;
      Reset_n = 1'b0;
      #1;
      check("async_rst_pend",  Walk_Pending, 0);
      check("async_rst_count", WR_Count,     0);
      check("async_rst_valid", Sensor_Valid, 0);
      tick();
      WR_Sync = 1'b0;
      Reset_n = 1'b1;
      tick();
      check("post_rst_pend", Walk_Pending, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
